ctrl_seq: RTL

CTRL_SEQ -- requirements
Module: ctrl_seq

---
 rtl/ctrl_seq_pkg.sv | 68 ++++++
 rtl/ctrl_seq_instr_decode.sv | 49 ++++
 rtl/ctrl_seq.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_seq_pkg.sv
// Shared constants and types for the ctrl_seq control sequencer.
// Opcode map, FSM encoding, ALU codes, branch conditions and link register.
package ctrl_seq_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_ST   = 5'd1;
    localparam logic [4:0] OP_ADD  = 5'd2;
    localparam logic [4:0] OP_SUB  = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_OR   = 5'd5;
    localparam logic [4:0] OP_XOR  = 5'd6;
    localparam logic [4:0] OP_ADDI = 5'd7;
    localparam logic [4:0] OP_ANDI = 5'd8;
    localparam logic [4:0] OP_ORI  = 5'd9;
    localparam logic [4:0] OP_MUL  = 5'd10;
    localparam logic [4:0] OP_DIV  = 5'd11;
    localparam logic [4:0] OP_MFHI = 5'd12;
    localparam logic [4:0] OP_MFLO = 5'd13;
    localparam logic [4:0] OP_BR   = 5'd14;
    localparam logic [4:0] OP_JR   = 5'd15;
    localparam logic [4:0] OP_JAL  = 5'd16;
    localparam logic [4:0] OP_NOP  = 5'd17;
    localparam logic [4:0] OP_HALT = 5'd31;

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WBLATCH,
        S_COMMIT,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU,
        CLS_MULDIV,
        CLS_MFHL,
        CLS_LD,
        CLS_ST,
        CLS_BR,
        CLS_JR,
        CLS_JAL,
        CLS_NOP,
        CLS_HALT
    } cls_t;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_MUL = 4'd5;
    localparam logic [3:0] ALU_DIV = 4'd6;

    localparam logic [1:0] C2_ZERO  = 2'b00;
    localparam logic [1:0] C2_NZERO = 2'b01;
    localparam logic [1:0] C2_POS   = 2'b10;
    localparam logic [1:0] C2_NEG   = 2'b11;

    localparam logic [3:0] LINK_REG = 4'd8;

    function automatic logic [31:0] sext19(input logic [18:0] v);
        return {{13{v[18]}}, v};
    endfunction

endpackage

// File: rtl/ctrl_seq_instr_decode.sv
// Combinational opcode decoder for ctrl_seq.
// Maps opcode to instruction class, ALU control and imm/hi-lo flags.
module instr_decode
    import ctrl_seq_pkg::*;
(
    input  logic [4:0] opcode,
    output cls_t       cls,
    output logic [3:0] alu_ctrl,
    output logic       imm_form,
    output logic       hi_sel
);

    always_comb begin
        cls      = CLS_HALT;
        alu_ctrl = ALU_ADD;
        imm_form = 1'b0;
        hi_sel   = 1'b0;
        case (opcode)
            OP_LD:   begin cls = CLS_LD;  imm_form = 1'b1; end
            OP_ST:   begin cls = CLS_ST;  imm_form = 1'b1; end
            OP_ADD:  cls = CLS_ALU;
            OP_SUB:  begin cls = CLS_ALU; alu_ctrl = ALU_SUB; end
            OP_AND:  begin cls = CLS_ALU; alu_ctrl = ALU_AND; end
            OP_OR:   begin cls = CLS_ALU; alu_ctrl = ALU_OR;  end
            OP_XOR:  begin cls = CLS_ALU; alu_ctrl = ALU_XOR; end
            OP_ADDI: begin cls = CLS_ALU; imm_form = 1'b1; end
            OP_ANDI: begin
                cls      = CLS_ALU;
                alu_ctrl = ALU_AND;
                imm_form = 1'b1;
            end
            OP_ORI:  begin
                cls      = CLS_ALU;
                alu_ctrl = ALU_OR;
                imm_form = 1'b1;
            end
            OP_MUL:  begin cls = CLS_MULDIV; alu_ctrl = ALU_MUL; end
            OP_DIV:  begin cls = CLS_MULDIV; alu_ctrl = ALU_DIV; end
            OP_MFHI: begin cls = CLS_MFHL; hi_sel = 1'b1; end
            OP_MFLO: cls = CLS_MFHL;
            OP_BR:   cls = CLS_BR;
            OP_JR:   cls = CLS_JR;
            OP_JAL:  cls = CLS_JAL;
            OP_NOP:  cls = CLS_NOP;
            default: cls = CLS_HALT;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer driving PC, register file, ALU and memory.
// Optional memory wait timeout: define CTRL_SEQ_MEM_TIMEOUT_EN.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        iClk,
    input  logic        nRst,
    input  logic [31:0] iMemData,
    input  logic        iMemReady,
    output logic        oMemRead,
    output logic        oMemWrite,
    input  logic        iJ_zero,
    input  logic        iJ_nZero,
    input  logic        iJ_pos,
    input  logic        iJ_neg,
    output logic        oPC_nRst,
    output logic        oPC_en,
    output logic        oPC_load,
    output logic        oPC_offset,
    output logic        oRF_Write,
    output logic        oRWB_en,
    output logic        oRA_en,
    output logic        oRB_en,
    output logic        oRZH_en,
    output logic        oRZL_en,
    output logic        oRAS_en,
    output logic        oMUX_BIS,
    output logic        oMUX_RZHS,
    output logic        oMUX_WBM,
    output logic        oMUX_MAP,
    output logic        oMUX_ASS,
    output logic        oMUX_WBP,
    output logic [3:0]  oRF_AddrA,
    output logic [3:0]  oRF_AddrB,
    output logic [3:0]  oRF_AddrC,
    output logic [3:0]  oALU_Ctrl,
    output logic [31:0] oImm32,
    output logic        oHalt,
    output logic        oFault
);

    state_t      state_q, state_d;
    logic [31:0] ir_q;
    logic        ir_ld;
    cls_t        cls;
    logic [3:0]  alu_ctrl;
    logic        imm_form, hi_sel;
    logic [3:0]  ra, rb, rc;
    logic [1:0]  c2;
    logic        br_taken;
    logic        mem_wait;
    logic        timeout;

    assign ra = ir_q[26:23];
    assign rb = ir_q[22:19];
    assign rc = ir_q[18:15];
    assign c2 = ir_q[20:19];

    instr_decode u_dec (
        .opcode   (ir_q[31:27]),
        .cls      (cls),
        .alu_ctrl (alu_ctrl),
        .imm_form (imm_form),
        .hi_sel   (hi_sel)
    );

    always_comb begin
        case (c2)
            C2_ZERO:  br_taken = iJ_zero;
            C2_NZERO: br_taken = iJ_nZero;
            C2_POS:   br_taken = iJ_pos;
            default:  br_taken = iJ_neg;
        endcase
    end

    assign mem_wait = !iMemReady &&
                      (state_q == S_FETCH || state_q == S_MEM);

`ifdef CTRL_SEQ_MEM_TIMEOUT_EN
    localparam int CW = $clog2(MEM_WAIT_MAX + 1);
    logic [CW-1:0] wait_cnt;
    logic          fault_q;

    assign timeout = mem_wait && (wait_cnt == CW'(MEM_WAIT_MAX - 1));
    assign oFault  = fault_q;

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            if (state_d != state_q)
                wait_cnt <= '0;
            else if (mem_wait)
                wait_cnt <= wait_cnt + 1'b1;
            if (timeout)
                fault_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign oFault  = 1'b0;
`endif

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_q <= S_RESET;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (ir_ld)
                ir_q <= iMemData;
        end
    end

    assign oImm32 = (state_q == S_RESET) ? 32'd0 : sext19(ir_q[18:0]);
    assign oHalt  = (state_q == S_HALT);

    always_comb begin
        state_d    = state_q;
        ir_ld      = 1'b0;
        oMemRead   = 1'b0;
        oMemWrite  = 1'b0;
        oPC_nRst   = 1'b1;
        oPC_en     = 1'b0;
        oPC_load   = 1'b0;
        oPC_offset = 1'b0;
        oRF_Write  = 1'b0;
        oRWB_en    = 1'b0;
        oRA_en     = 1'b0;
        oRB_en     = 1'b0;
        oRZH_en    = 1'b0;
        oRZL_en    = 1'b0;
        oRAS_en    = 1'b0;
        oMUX_BIS   = 1'b0;
        oMUX_RZHS  = 1'b0;
        oMUX_WBM   = 1'b0;
        oMUX_MAP   = 1'b0;
        oMUX_ASS   = 1'b0;
        oMUX_WBP   = 1'b0;
        oRF_AddrA  = 4'd0;
        oRF_AddrB  = 4'd0;
        oRF_AddrC  = 4'd0;
        oALU_Ctrl  = 4'd0;

        // Operand addresses stay stable from DECODE through EXEC
        if (state_q == S_DECODE || state_q == S_EXEC) begin
            oRF_AddrA = rb;
            if ((cls == CLS_ALU && !imm_form) || cls == CLS_MULDIV)
                oRF_AddrB = rc;
            else if (cls == CLS_ST || cls == CLS_BR)
                oRF_AddrB = ra;
        end

        unique case (state_q)
            S_RESET: begin
                oPC_nRst = 1'b0;
                state_d  = S_FETCH;
            end
            S_FETCH: begin
                oMUX_MAP = 1'b1;
                oMemRead = 1'b1;
                if (iMemReady) begin
                    ir_ld   = 1'b1;
                    oPC_en  = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                oRA_en  = 1'b1;
                oRB_en  = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (cls)
                    CLS_ALU: begin
                        oALU_Ctrl = alu_ctrl;
                        oMUX_BIS  = imm_form;
                        oRZL_en   = 1'b1;
                        state_d   = S_WBLATCH;
                    end
                    CLS_MULDIV: begin
                        oALU_Ctrl = alu_ctrl;
                        oRAS_en   = 1'b1;
                        oRZH_en   = 1'b1;
                        oRZL_en   = 1'b1;
                    end
                    CLS_MFHL: begin
                        oMUX_ASS  = 1'b1;
                        oMUX_RZHS = hi_sel;
                        oRZL_en   = 1'b1;
                        state_d   = S_WBLATCH;
                    end
                    CLS_LD, CLS_ST: begin
                        oALU_Ctrl = ALU_ADD;
                        oMUX_BIS  = 1'b1;
                        oRZL_en   = 1'b1;
                        state_d   = S_MEM;
                    end
                    CLS_BR: begin
                        oPC_offset = br_taken;
                        oPC_en     = br_taken;
                    end
                    CLS_JR: begin
                        oRF_AddrA = ra;
                        oPC_load  = 1'b1;
                        oPC_en    = 1'b1;
                    end
                    CLS_JAL: begin
                        oMUX_WBP = 1'b1;
                        oRWB_en  = 1'b1;
                        state_d  = S_COMMIT;
                    end
                    CLS_NOP: state_d = S_FETCH;
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                oMemRead  = (cls == CLS_LD);
                oMemWrite = (cls != CLS_LD);
                if (iMemReady)
                    state_d = (cls == CLS_LD) ? S_WBLATCH : S_FETCH;
                else if (timeout)
                    state_d = S_HALT;
            end
            S_WBLATCH: begin
                oRWB_en  = 1'b1;
                oMUX_WBM = (cls == CLS_LD);
                state_d  = S_COMMIT;
            end
            S_COMMIT: begin
                oRF_Write = 1'b1;
                oRF_AddrC = ra;
                if (cls == CLS_JAL) begin
                    oRF_AddrC = LINK_REG;
                    oRF_AddrA = ra;
                    oPC_load  = 1'b1;
                    oPC_en    = 1'b1;
                end
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
        endcase
    end

endmodule
